// File: rtl/td4_prog_loader.sv
// Writable 16x8 program store and nibble-by-nibble loader for the TD4 core.
// Define TD4_DEFAULT_PROG_EN to make reset load the demo image instead of all zeros.
module td4_prog_loader (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_mode,
  input  logic [3:0] nib,
  input  logic       nib_stb,
  input  logic [3:0] addr,
  output logic [7:0] ramdata,
  output logic       core_reset,
  output logic [3:0] wptr,
  output logic       full
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_FULL = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [3:0] hi_r;
  logic [3:0] hi_s;
  logic [3:0] wptr_r;
  logic [3:0] wptr_s;
  logic       full_r;
  logic       full_s;
  logic       core_reset_r;
  logic       core_reset_s;
  logic       wr_en_s;
  logic [7:0] wr_data_s;
  logic [7:0] mem_r [16];

  function automatic logic [7:0] power_on_byte(input logic [3:0] idx);
`ifdef TD4_DEFAULT_PROG_EN
    case (idx)
      4'd0:    power_on_byte = 8'hB7;
      4'd1:    power_on_byte = 8'h01;
      4'd2:    power_on_byte = 8'hE1;
      4'd3:    power_on_byte = 8'h01;
      4'd4:    power_on_byte = 8'hE3;
      4'd5:    power_on_byte = 8'hB6;
      4'd6:    power_on_byte = 8'h01;
      4'd7:    power_on_byte = 8'hE6;
      4'd8:    power_on_byte = 8'h01;
      4'd9:    power_on_byte = 8'hE8;
      4'd10:   power_on_byte = 8'hB0;
      4'd11:   power_on_byte = 8'hB4;
      4'd12:   power_on_byte = 8'h01;
      4'd13:   power_on_byte = 8'hEA;
      4'd14:   power_on_byte = 8'hB8;
      default: power_on_byte = 8'hFF;
    endcase
`else
    case (idx)
      default: power_on_byte = 8'h00;
    endcase
`endif
  endfunction

  // Next-state logic; dropping load_mode wins over a simultaneous strobe.
  always_comb begin
    state_s   = state_r;
    hi_s      = hi_r;
    wptr_s    = wptr_r;
    full_s    = full_r;
    wr_en_s   = 1'b0;
    wr_data_s = {hi_r, nib};
    case (state_r)
      ST_RUN: begin
        if (load_mode) begin
          state_s = ST_HI;
          wptr_s  = 4'd0;
          full_s  = 1'b0;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_HI: begin
        if (!load_mode) begin
          state_s = ST_RUN;
        end else if (nib_stb) begin
          hi_s    = nib;
          state_s = ST_LO;
        end else begin
          state_s = ST_HI;
        end
      end
      ST_LO: begin
        if (!load_mode) begin
          state_s = ST_RUN;
        end else if (nib_stb) begin
          wr_en_s = 1'b1;
          if (wptr_r == 4'd15) begin
            full_s  = 1'b1;
            state_s = ST_FULL;
          end else begin
            wptr_s  = wptr_r + 4'd1;
            state_s = ST_HI;
          end
        end else begin
          state_s = ST_LO;
        end
      end
      ST_FULL: begin
        if (!load_mode) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_FULL;
        end
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
    core_reset_s = (state_s == ST_RUN);
  end

  // Loader state and registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_RUN;
      hi_r         <= 4'd0;
      wptr_r       <= 4'd0;
      full_r       <= 1'b0;
      core_reset_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      hi_r         <= hi_s;
      wptr_r       <= wptr_s;
      full_r       <= full_s;
      core_reset_r <= core_reset_s;
    end
  end

  // Program store; reset restores the power-on image.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        mem_r[i] <= power_on_byte(4'(i));
      end
    end else if (wr_en_s) begin
      mem_r[wptr_r] <= wr_data_s;
    end
  end

  assign ramdata    = mem_r[addr];
  assign core_reset = core_reset_r;
  assign wptr       = wptr_r;
  assign full       = full_r;

endmodule
